// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA display designs: 640x480@60 timing,
// sync polarities and the 10-bit raster position type.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // 0 = active-low sync pulse
  localparam bit H_SYNC_POL = 1'b0;
  localparam bit V_SYNC_POL = 1'b0;

  localparam int POS_W = 10;
  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/vga_timing_core_wrap_counter.sv
// Enabled modulo counter 0..MAX. Resets to MAX so the first enabled cycle
// lands on 0. wrap is a combinational one-cycle pulse that is high in the
// cycle where an enabled step takes count from MAX back to 0, letting a
// chained counter advance on the same edge.
module wrap_counter #(
  parameter int MAX   = 799,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap  = en && (count_q == MAX_V);
  assign count = count_q;

  // Next count: step on en, fold back to 0 after MAX.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // Count register, synchronous active-low reset to MAX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= MAX_V;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_core.sv
// Raster timing generator: hpos/vpos counters, display_on, hsync/vsync and
// per-line / per-frame strobes, all registered from next-state counter
// values so every output is aligned with hpos/vpos.
// Optional build macro VGA_FRAME_COUNTER_EN adds an 8-bit frame_cnt output.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BACK     = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY  = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BACK     = vga_timing_pkg::V_BACK,
  parameter bit H_SYNC_POL = vga_timing_pkg::H_SYNC_POL,
  parameter bit V_SYNC_POL = vga_timing_pkg::V_SYNC_POL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam pos_t H_DISP_P = pos_t'(H_DISPLAY);
  localparam pos_t V_DISP_P = pos_t'(V_DISPLAY);
  localparam pos_t HS_FIRST = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HS_LAST  = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam pos_t VS_FIRST = pos_t'(V_DISPLAY + V_FRONT);
  localparam pos_t VS_LAST  = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Positions are fixed at 10 bits; larger rasters cannot be represented.
  if (H_TOT > 1024) begin : g_h_total_check
    $error("vga_timing_core: horizontal total exceeds 1024");
  end
  if (V_TOT > 1024) begin : g_v_total_check
    $error("vga_timing_core: vertical total exceeds 1024");
  end

  pos_t h_cnt, v_cnt;
  pos_t h_d, v_d;
  logic h_wrap, v_wrap, v_en;

  assign v_en = pix_ce && h_wrap;

  wrap_counter #(.MAX(H_TOT - 1), .WIDTH(POS_W)) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_ce),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  wrap_counter #(.MAX(V_TOT - 1), .WIDTH(POS_W)) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_en),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  assign hpos = h_cnt;
  assign vpos = v_cnt;

  logic display_on_q, display_on_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Derive the position the counters will hold after this edge, then the
  // outputs that belong to that position. Strobes fire only on the pix_ce
  // step into hpos 0; all level outputs hold while pix_ce is low.
  always_comb begin
    h_d           = h_cnt;
    v_d           = v_cnt;
    display_on_d  = display_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      h_d           = h_wrap ? '0 : h_cnt + 1'b1;
      v_d           = v_en ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
      display_on_d  = (h_d < H_DISP_P) && (v_d < V_DISP_P);
      hsync_d       = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? H_SYNC_POL : !H_SYNC_POL;
      vsync_d       = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? V_SYNC_POL : !V_SYNC_POL;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
  end

  // Output registers; reset parks them in the blanked, sync-inactive state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_on_q  <= 1'b0;
      hsync_q       <= !H_SYNC_POL;
      vsync_q       <= !V_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      display_on_q  <= display_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign display_on  = display_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Frame counter steps with frame_start; resets to FF so frame 0 reads 0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'hFF;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_core.md
Name: vga_timing_core

Overview:
Upstream raster-timing stage for the VGA display designs, including the bouncing-logo top.
- Generates hsync, vsync, display_on and the raster position.
- Generates per-line and per-frame strobes, so downstream motion logic needs no edge-detect of vpos.
- Default timing: 640x480@60 Hz, 25.175 MHz pixel clock (25 MHz acceptable).
- The pixel clock-enable lets the block run from a faster system clock.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- pix_ce  input  1  pixel clock-enable; counters advance only when high (tie to 1 for native pixel clock)
- hpos  output  10  current column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- display_on  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- hsync  output  1  horizontal sync at H_SYNC_POL level during the sync window
- vsync  output  1  vertical sync at V_SYNC_POL level during the sync window
- line_start  output  1  one-pix_ce pulse when hpos==0
- frame_start  output  1  one-pix_ce pulse when hpos==0 and vpos==0

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Widths are fixed at 10 bits; elaborate-time error if either total exceeds 1024.
- Reset (rst_n low at a clk edge):
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1.
  - display_on=0, hsync=!H_SYNC_POL, vsync=!V_SYNC_POL.
  - line_start=0, frame_start=0.
- First advance after reset: the first pix_ce=1 cycle after release moves the counters to (0,0) and asserts frame_start and line_start. Frame 0 is therefore always flagged.
- hpos: increments on pix_ce; wraps from H_TOTAL-1 to 0.
- vpos: increments only on the pix_ce cycle where hpos wraps; wraps from V_TOTAL-1 to 0 at the same edge.
- All outputs are registered and computed from next-state counter values. They are cycle-aligned with hpos/vpos, with zero skew between any two outputs.
- hsync active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = 656..751.
- vsync active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = 490..491. vsync is level-per-line and not offset by hpos.
- Strobe gating: line_start and frame_start are high only in the clk cycle where pix_ce caused the transition into hpos=0. They are low on all other cycles, even while hpos stays 0 with pix_ce low.
- pix_ce low: every output holds its value.
- Reset mid-frame: restores the reset state on the next edge, regardless of pix_ce.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN.
- Defined: adds output port frame_cnt (8 bits).
  - Reset value 8'hFF.
  - Increments on every cycle frame_start asserts, so the first frame after reset reads 0.
  - Wraps 255->0.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 constants (H_DISPLAY..V_BACK, H_TOTAL, V_TOTAL);
  - the sync polarity constants;
  - a 10-bit position typedef.
- Sub-module wrap_counter (params MAX, WIDTH; ports clk, rst_n, en, count, wrap):
  - instantiated twice, horizontal en=pix_ce and vertical en=pix_ce&h_wrap;
  - wrap is a one-cycle pulse.

Test Plan:
- Reset release with pix_ce=1 → next cycle hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1; following cycle both strobes 0, hpos=1.
- Run 800 cycles from (0,0) → hsync low exactly for hpos 656..751 (96 cycles); display_on high for hpos 0..639; line_start pulses again at cycle 800 with vpos=1.
- Run a full frame of 420000 cycles → vsync low exactly while vpos in 490..491 (1600 cycles); frame_start pulses exactly once per 420000 cycles; display_on count = 307200.
- pix_ce toggling 1,0,0,1 → hpos advances only on ce cycles; a strobe entered on a ce cycle is not re-asserted during the following ce=0 cycles.
- Assert rst_n=0 at (hpos=300, vpos=200) with pix_ce=0 → next edge hpos=799, vpos=524, all syncs inactive; on release, (0,0) with frame_start=1.
- With VGA_FRAME_COUNTER_EN defined: run 257 frames → frame_cnt reads 0 in frame 0, 255 in frame 255, 0 again in frame 256.
